cascade_lpf: RTL and testbench

- Parameterised chain of identical 2-tap moving-average low-pass stages on a 16-bit signed sample stream.
- Each stage can be individually enabled at run time.
- Sits after the sine generator or ADC front end in the OPO locking datapath and smooths error and dither signals.
- Frequency response is characterised by sweeping a sine generator tone through instances with 0, 1, 2, 4 … 2048 stages.

---
 rtl/opo_pkg.sv | 14 +
 rtl/cascade_lpf_if.sv | 35 +++
 rtl/lpf_stage.sv | 45 ++++
 rtl/cascade_lpf.sv | 47 ++++
 tb/tb_cascade_lpf.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/opo_pkg.sv
// Shared definitions for the OPO locking datapath: sample width, sample type
// and a helper that sizes per-stage enable vectors.
package opo_pkg;

    localparam int WORD_WIDTH = 16;

    typedef logic signed [WORD_WIDTH-1:0] sample_t;

    // Enable vectors keep at least one bit so a zero-stage build still has a legal port.
    function automatic int en_width(input int num_stages);
        return (num_stages > 0) ? num_stages : 1;
    endfunction

endpackage

// File: rtl/cascade_lpf_if.sv
// Sample stream bundle for cascade_lpf: input sample, per-stage enables,
// and filtered output sample.
interface cascade_lpf_if #(
    parameter int NUM_STAGES = 1,
    parameter int WORD_WIDTH = opo_pkg::WORD_WIDTH
) ();
    import opo_pkg::*;

    localparam int EN_W = en_width(NUM_STAGES);

    // Valid-only stream: a sample moves on every clock edge where its valid is
    // high; there is no ready/backpressure, so the consumer must always accept.
    logic [EN_W-1:0]              stage_en;
    logic signed [WORD_WIDTH-1:0] din;
    logic                         din_valid;
    logic signed [WORD_WIDTH-1:0] dout;
    logic                         dout_valid;

    modport master (
        output stage_en,
        output din,
        output din_valid,
        input  dout,
        input  dout_valid
    );

    modport slave (
        input  stage_en,
        input  din,
        input  din_valid,
        output dout,
        output dout_valid
    );

endinterface

// File: rtl/lpf_stage.sv
// One 2-tap moving-average stage: y = floor((x + previous x) / 2) when
// enabled, y = x when disabled; always one register of latency.
module lpf_stage #(
    parameter int WORD_WIDTH = opo_pkg::WORD_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_en,
    input  logic signed [WORD_WIDTH-1:0] i_x,
    input  logic                         i_v,
    output logic signed [WORD_WIDTH-1:0] o_y,
    output logic                         o_vo
);

    logic signed [WORD_WIDTH-1:0] r_xp;
    logic signed [WORD_WIDTH-1:0] r_y;
    logic                         r_vo;

    logic signed [WORD_WIDTH:0]   w_sum;
    logic signed [WORD_WIDTH-1:0] w_avg;
    logic signed [WORD_WIDTH-1:0] w_next;

    // One extra bit holds the full sum; the halved value always fits back in WORD_WIDTH.
    assign w_sum  = $signed({i_x[WORD_WIDTH-1], i_x}) + $signed({r_xp[WORD_WIDTH-1], r_xp});
    assign w_avg  = WORD_WIDTH'(w_sum >>> 1);
    assign w_next = i_en ? w_avg : i_x;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_xp <= '0;
            r_y  <= '0;
            r_vo <= 1'b0;
        end else begin
            r_vo <= i_v;
            if (i_v) begin
                r_xp <= i_x;
                r_y  <= w_next;
            end
        end
    end

    assign o_y  = r_y;
    assign o_vo = r_vo;

endmodule

// File: rtl/cascade_lpf.sv
// Chain of NUM_STAGES run-time-enableable 2-tap averaging stages; zero
// stages degenerates to a combinational wire-through.
module cascade_lpf
    import opo_pkg::*;
#(
    parameter int NUM_STAGES = 1,
    parameter int WORD_WIDTH = opo_pkg::WORD_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    cascade_lpf_if.slave  bus
);

    generate
        if (NUM_STAGES == 0) begin : g_bypass
            logic w_unused;
            assign w_unused       = ^{clk, rst, bus.stage_en};
            assign bus.dout       = bus.din;
            assign bus.dout_valid = bus.din_valid;
        end else begin : g_chain
            // Index 0 is the chain input; index i+1 is the output of stage i.
            logic signed [WORD_WIDTH-1:0] w_x [NUM_STAGES+1];
            logic                         w_v [NUM_STAGES+1];

            assign w_x[0] = bus.din;
            assign w_v[0] = bus.din_valid;

            for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
                lpf_stage #(
                    .WORD_WIDTH (WORD_WIDTH)
                ) u_stage (
                    .clk  (clk),
                    .rst  (rst),
                    .i_en (bus.stage_en[i]),
                    .i_x  (w_x[i]),
                    .i_v  (w_v[i]),
                    .o_y  (w_x[i+1]),
                    .o_vo (w_v[i+1])
                );
            end

            assign bus.dout       = w_x[NUM_STAGES];
            assign bus.dout_valid = w_v[NUM_STAGES];
        end
    endgenerate

endmodule

// File: tb/tb_cascade_lpf.sv
// Directed bench for cascade_lpf with 0, 1, 2 and 4 stage instances.
module tb_cascade_lpf;
    import opo_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    cascade_lpf_if #(.NUM_STAGES(0)) if0 ();
    cascade_lpf_if #(.NUM_STAGES(1)) if1 ();
    cascade_lpf_if #(.NUM_STAGES(2)) if2 ();
    cascade_lpf_if #(.NUM_STAGES(4)) if4 ();

    cascade_lpf #(.NUM_STAGES(0)) u_dut0 (.clk(clk), .rst(rst_n), .bus(if0.slave));
    cascade_lpf #(.NUM_STAGES(1)) u_dut1 (.clk(clk), .rst(rst_n), .bus(if1.slave));
    cascade_lpf #(.NUM_STAGES(2)) u_dut2 (.clk(clk), .rst(rst_n), .bus(if2.slave));
    cascade_lpf #(.NUM_STAGES(4)) u_dut4 (.clk(clk), .rst(rst_n), .bus(if4.slave));

    typedef struct {
        sample_t    din;
        logic       vin;
        logic [3:0] en;
        sample_t    exp_dout;
        logic       exp_vout;
    } vec_t;

    vec_t tbl[$];
    logic [WORD_WIDTH-1:0] exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input int din, input logic vin, input logic [3:0] en,
                       input int ed, input logic ev);
        vec_t v;
        v.din      = WORD_WIDTH'(din);
        v.vin      = vin;
        v.en       = en;
        v.exp_dout = WORD_WIDTH'(ed);
        v.exp_vout = ev;
        tbl.push_back(v);
    endtask

    task automatic drive(input int which, input vec_t v);
        case (which)
            1: begin if1.din = v.din; if1.din_valid = v.vin; if1.stage_en = v.en[0];   end
            2: begin if2.din = v.din; if2.din_valid = v.vin; if2.stage_en = v.en[1:0]; end
            default: begin if4.din = v.din; if4.din_valid = v.vin; if4.stage_en = v.en; end
        endcase
    endtask

    task automatic read_out(input int which, output int d, output int vld);
        case (which)
            1: begin d = if1.dout; vld = int'(if1.dout_valid); end
            2: begin d = if2.dout; vld = int'(if2.dout_valid); end
            default: begin d = if4.dout; vld = int'(if4.dout_valid); end
        endcase
    endtask

    task automatic run_tbl(input int which, input string name);
        int d, vld;
        foreach (tbl[k]) begin
            drive(which, tbl[k]);
            @(posedge clk);
            #1;
            read_out(which, d, vld);
            chk($sformatf("%s[%0d].dout", name, k), d, int'(tbl[k].exp_dout));
            chk($sformatf("%s[%0d].valid", name, k), vld, int'(tbl[k].exp_vout));
        end
        tbl.delete();
    endtask

    task automatic chk_zero_all(input string tag);
        chk({tag, ".n1.dout"},  int'(if1.dout), 0);
        chk({tag, ".n1.valid"}, int'(if1.dout_valid), 0);
        chk({tag, ".n2.dout"},  int'(if2.dout), 0);
        chk({tag, ".n2.valid"}, int'(if2.dout_valid), 0);
        chk({tag, ".n4.dout"},  int'(if4.dout), 0);
        chk({tag, ".n4.valid"}, int'(if4.dout_valid), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int imp[5];
        int d, vld;
        imp = '{1024, 4096, 6144, 4096, 1024};

        if0.din = '0; if0.din_valid = 1'b0; if0.stage_en = '1;
        if1.din = '0; if1.din_valid = 1'b0; if1.stage_en = '1;
        if2.din = '0; if2.din_valid = 1'b0; if2.stage_en = '1;
        if4.din = '0; if4.din_valid = 1'b0; if4.stage_en = '1;

        // Clock/reset: assert, hold over two edges, release on a falling edge.
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero_all("reset");
        @(negedge clk) rst_n = 1'b1;

        // Zero stages: combinational passthrough.
        if0.din = 16'sd1234; if0.din_valid = 1'b1; #1;
        chk("n0.a.dout", int'(if0.dout), 1234);
        chk("n0.a.valid", int'(if0.dout_valid), 1);
        if0.din = -16'sd5; if0.din_valid = 1'b0; #1;
        chk("n0.b.dout", int'(if0.dout), -5);
        chk("n0.b.valid", int'(if0.dout_valid), 0);
        if0.din = 16'sh7FFF; if0.din_valid = 1'b1; #1;
        chk("n0.c.dout", int'(if0.dout), 32767);
        chk("n0.c.valid", int'(if0.dout_valid), 1);
        if0.din = 16'sh8000; if0.din_valid = 1'b0; #1;
        chk("n0.d.dout", int'(if0.dout), -32768);
        chk("n0.d.valid", int'(if0.dout_valid), 0);

        // One stage: DC step, Nyquist alternation, floor rounding, bypass, hold.
        add(1000, 1, 4'h1, 500, 1);
        add(1000, 1, 4'h1, 1000, 1);
        add(1000, 1, 4'h1, 1000, 1);
        add(-1000, 1, 4'h1, 0, 1);
        add(1000, 1, 4'h1, 0, 1);
        add(-1000, 1, 4'h1, 0, 1);
        add(1000, 1, 4'h1, 0, 1);
        add(0, 1, 4'h1, 500, 1);
        add(-1, 1, 4'h1, -1, 1);
        add(-1, 1, 4'h1, -1, 1);
        add(1, 1, 4'h1, 0, 1);
        add(2, 1, 4'h1, 1, 1);
        add(77, 1, 4'h0, 77, 1);
        add(5, 0, 4'h0, 77, 0);
        add(5, 0, 4'h1, 77, 0);
        add(3, 1, 4'h1, 40, 1);
        run_tbl(1, "n1");
        if1.din_valid = 1'b0;

        // Two stages: extremes with gapped valid.
        add(32767, 1, 4'h3, 0, 0);
        add(0, 0, 4'h3, 8191, 1);
        add(32767, 1, 4'h3, 8191, 0);
        add(0, 0, 4'h3, 24575, 1);
        add(-32768, 1, 4'h3, 24575, 0);
        add(0, 0, 4'h3, 16383, 1);
        add(-32768, 1, 4'h3, 16383, 0);
        add(0, 0, 4'h3, -16385, 1);
        add(32767, 1, 4'h3, -16385, 0);
        add(0, 0, 4'h3, -16385, 1);
        add(-32768, 1, 4'h3, -16385, 0);
        add(0, 0, 4'h3, -1, 1);
        add(0, 0, 4'h3, -1, 0);
        add(0, 0, 4'h3, -1, 0);
        run_tbl(2, "n2");

        // Four stages: impulse gives the binomial kernel after four clocks.
        for (int c = 0; c < 12; c++) begin
            add((c == 0) ? 16384 : 0, 1, 4'hF,
                (c >= 3 && c < 8) ? imp[c-3] : 0, (c >= 3));
        end
        run_tbl(4, "n4imp");

        // Four stages all bypassed: ramp emerges delayed, checked from a queue.
        repeat (3) exp_q.push_back('0);
        for (int c = 0; c < 12; c++) begin
            logic [WORD_WIDTH-1:0] e;
            if4.din = WORD_WIDTH'(c); if4.din_valid = 1'b1; if4.stage_en = 4'h0;
            exp_q.push_back(WORD_WIDTH'(c));
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            read_out(4, d, vld);
            chk($sformatf("n4ramp[%0d].dout", c), d, int'($signed(e)));
            chk($sformatf("n4ramp[%0d].valid", c), vld, 1);
        end

        // Mid-stream reset: asynchronous clear, then restart from zero history.
        if1.din = 16'sd1000; if1.din_valid = 1'b1; if1.stage_en = 1'b1;
        if2.din = 16'sd1000; if2.din_valid = 1'b1; if2.stage_en = 2'b11;
        if4.din = 16'sd1000; if4.din_valid = 1'b1; if4.stage_en = 4'hF;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_zero_all("midrst");
        @(posedge clk);
        #1;
        chk_zero_all("midrst_hold");
        if1.din_valid = 1'b0; if2.din_valid = 1'b0; if4.din_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;

        add(1000, 1, 4'h1, 500, 1);
        add(1000, 1, 4'h1, 1000, 1);
        run_tbl(1, "n1rst");
        if1.din_valid = 1'b0;

        add(16384, 1, 4'hF, 0, 0);
        add(0, 1, 4'hF, 0, 0);
        add(0, 1, 4'hF, 0, 0);
        add(0, 1, 4'hF, 1024, 1);
        add(0, 1, 4'hF, 4096, 1);
        run_tbl(4, "n4rst");
        if4.din_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
